// File: rtl/truth_table_capture.sv
// Sweeps every input vector of a single-output combinational function, packs the
// sampled outputs into words and streams them to a valid/ready consumer.
module truth_table_capture #(
  parameter int N_IN   = 10,
  parameter int WORD_W = 32,
  parameter int SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   dut_x,
  input  logic              dut_y,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN:0]     ones_count,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [N_IN:0]  LAST_VEC  = {1'b0, {N_IN{1'b1}}};
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SAMPLE,
    EMIT,
    FINISH
  } state_t;

  // With no settle time a vector is sampled in the very cycle it is applied.
  localparam state_t VEC_ENTRY = (SETTLE == 0) ? SAMPLE : APPLY;

  state_t state, state_nxt;

  logic [N_IN:0]     vec;
  logic [WORD_W-1:0] word;
  logic [N_IN:0]     ones;
  logic [SET_W-1:0]  settle_cnt;

  logic [BIT_W-1:0] bit_pos;
  logic             word_last;
  logic             settle_done;

  logic clear_all;
  logic take_sample;
  logic advance;
  logic clear_word;
  logic end_sweep;

  assign bit_pos     = vec[BIT_W-1:0];
  assign word_last   = (bit_pos == LAST_BIT);
  assign settle_done = (settle_cnt == LAST_SET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clear_all   = 1'b0;
    take_sample = 1'b0;
    advance     = 1'b0;
    clear_word  = 1'b0;
    end_sweep   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_all = 1'b1;
          state_nxt = VEC_ENTRY;
        end
      end
      APPLY: begin
        if (settle_done) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        take_sample = 1'b1;
        if (word_last) begin
          state_nxt = EMIT;
        end else begin
          advance   = 1'b1;
          state_nxt = VEC_ENTRY;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (vec == LAST_VEC) begin
            end_sweep = 1'b1;
            state_nxt = FINISH;
          end else begin
            advance    = 1'b1;
            clear_word = 1'b1;
            state_nxt  = VEC_ENTRY;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vector counter returns to zero after the sweep so dut_x idles at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= '0;
      word       <= '0;
      ones       <= '0;
      settle_cnt <= '0;
    end else begin
      if (clear_all) begin
        vec  <= '0;
        word <= '0;
        ones <= '0;
      end
      if (state == APPLY) begin
        settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
      if (take_sample) begin
        word[bit_pos] <= dut_y;
        ones          <= ones + (N_IN + 1)'(dut_y);
      end
      if (clear_word) begin
        word <= '0;
      end
      if (advance) begin
        vec <= vec + 1'b1;
      end
      if (end_sweep) begin
        vec <= '0;
      end
    end
  end

  assign dut_x      = vec[N_IN-1:0];
  assign out_data   = word;
  assign out_valid  = (state == EMIT);
  assign ones_count = ones;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: one instance with SETTLE = 0 and one
// with SETTLE = 2 driven by a registered (one-cycle-late) function model.
module tb_truth_table_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, ready, ready2;
  logic [9:0]  dx, dx2;
  logic        y, y2;
  logic [31:0] od, od2;
  logic        ov, ov2;
  logic [10:0] oc, oc2;
  logic        busy, busy2, done, done2;

  int sel;
  int tests = 0;
  int fails = 0;
  logic [31:0] got [0:31];
  int nrecv;
  int done_at;

  always_comb begin
    case (sel)
      1: y = dx[0];
      2: y = dx[9];
      3: y = dx[5];
      default: y = 1'b0;
    endcase
  end

  always_ff @(posedge clk) y2 <= dx2[0];

  truth_table_capture #(.N_IN(10), .WORD_W(32), .SETTLE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_x(dx), .dut_y(y),
    .out_data(od), .out_valid(ov), .out_ready(ready), .ones_count(oc),
    .busy(busy), .done(done)
  );

  truth_table_capture #(.N_IN(10), .WORD_W(32), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_x(dx2), .dut_y(y2),
    .out_data(od2), .out_valid(ov2), .out_ready(ready2), .ones_count(oc2),
    .busy(busy2), .done(done2)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int which);
    if (which == 0) start = 1'b1; else start2 = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Runs from cycle n0 after the start edge, accepting words and recording the
  // cycle on which done is seen; optional stall holds ready low on one word.
  task automatic collect(input int which, input int n0, input int limit,
                         input int stall_word, input int stall_len);
    int stall;
    logic v, d;
    logic [31:0] data;
    stall   = 0;
    nrecv   = 0;
    done_at = -1;
    for (int n = n0; n < limit; n++) begin
      v    = (which == 0) ? ov : ov2;
      d    = (which == 0) ? done : done2;
      data = (which == 0) ? od : od2;
      if (d) begin
        done_at = n;
        break;
      end
      if (v && nrecv == stall_word && stall < stall_len) begin
        if (which == 0) ready = 1'b0; else ready2 = 1'b0;
        check_output($sformatf("stall%0d_data", stall), od, 32'hFFFF_FFFF);
        check_output($sformatf("stall%0d_x", stall), {22'd0, dx}, 32'h0000_007F);
        stall++;
      end else begin
        if (which == 0) ready = 1'b1; else ready2 = 1'b1;
        if (v) begin
          if (nrecv < 32) got[nrecv] = data;
          nrecv++;
        end
      end
      tick();
    end
    ready  = 1'b1;
    ready2 = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_x"},     {22'd0, dx}, 32'd0);
    check_output({tag, "_data"},  od,          32'd0);
    check_output({tag, "_valid"}, {31'd0, ov}, 32'd0);
    check_output({tag, "_ones"},  {21'd0, oc}, 32'd0);
    check_output({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_output({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_word;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; ready = 1'b1; ready2 = 1'b1; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // y = 0
    sel = 0;
    apply_stimulus(0);
    check_output("t0_busy_at_start", {31'd0, busy}, 32'd1);
    check_output("t0_x_at_start", {22'd0, dx}, 32'd0);
    collect(0, 0, 1200, -1, 0);
    check_output("t0_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) check_output($sformatf("t0_word%0d", k), got[k], 32'h0);
    check_output("t0_ones", {21'd0, oc}, 32'd0);
    check_output("t0_done_cycle", done_at, 1056);
    tick();
    check_output("t0_busy_after", {31'd0, busy}, 32'd0);
    check_output("t0_done_after", {31'd0, done}, 32'd0);

    // y = x0
    sel = 1;
    apply_stimulus(0);
    collect(0, 0, 1200, -1, 0);
    check_output("t1_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) check_output($sformatf("t1_word%0d", k), got[k], 32'hAAAA_AAAA);
    check_output("t1_ones", {21'd0, oc}, 32'd512);
    check_output("t1_done_cycle", done_at, 1056);
    tick();

    // y = x9
    sel = 2;
    apply_stimulus(0);
    collect(0, 0, 1200, -1, 0);
    check_output("t2_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) begin
      exp_word = (k < 16) ? 32'h0 : 32'hFFFF_FFFF;
      check_output($sformatf("t2_word%0d", k), got[k], exp_word);
    end
    check_output("t2_ones", {21'd0, oc}, 32'd512);
    tick();

    // y = x5 with a 7-cycle stall on word 3
    sel = 3;
    apply_stimulus(0);
    collect(0, 0, 1200, 3, 7);
    check_output("t3_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) begin
      exp_word = (k % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
      check_output($sformatf("t3_word%0d", k), got[k], exp_word);
    end
    check_output("t3_ones", {21'd0, oc}, 32'd512);
    check_output("t3_done_cycle", done_at, 1063);
    tick();

    // mid-sweep start is ignored, reset at vector 100 aborts the sweep
    sel = 1;
    apply_stimulus(0);
    for (int i = 0; i < 200 && dx != 10'd50; i++) tick();
    check_output("t4_reach50", {22'd0, dx}, 32'd50);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("t4_x_after_start", {22'd0, dx}, 32'd51);
    check_output("t4_ones_after_start", {21'd0, oc}, 32'd25);
    check_output("t4_busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 200 && dx != 10'd100; i++) tick();
    check_output("t4_reach100", {22'd0, dx}, 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("t4_rst");
    tick();
    check_output("t4_idle_busy", {31'd0, busy}, 32'd0);
    check_output("t4_idle_x", {22'd0, dx}, 32'd0);
    apply_stimulus(0);
    collect(0, 0, 1200, -1, 0);
    check_output("t4_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) check_output($sformatf("t4_word%0d", k), got[k], 32'hAAAA_AAAA);
    check_output("t4_ones", {21'd0, oc}, 32'd512);
    check_output("t4_done_cycle", done_at, 1056);
    tick();

    // SETTLE = 2 with a registered y = x0 model
    apply_stimulus(1);
    check_output("t5_busy_at_start", {31'd0, busy2}, 32'd1);
    for (int n = 0; n < 9; n++) begin
      check_output($sformatf("t5_x_cycle%0d", n), {22'd0, dx2}, n / 3);
      tick();
    end
    collect(1, 9, 3300, -1, 0);
    check_output("t5_nwords", nrecv, 32);
    for (int k = 0; k < 32; k++) check_output($sformatf("t5_word%0d", k), got[k], 32'hAAAA_AAAA);
    check_output("t5_ones", {21'd0, oc2}, 32'd512);
    check_output("t5_done_cycle", done_at, 3104);
    tick();
    check_output("t5_busy_after", {31'd0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Sequential truth-table reader for the single-output, 10-input combinational benchmark netlists (inputs x0..x9, output y0). It drives every input vector 0..2^N_IN-1 into the function under test and samples the result. It packs the sampled bits into WORD_W-bit words and streams them out over a valid/ready handshake. It sits between a benchmark netlist and the host-side checker that compares captured truth tables against the original PLA, or against its autosymmetric reconstruction.

## Interface
Parameters:
- N_IN, 10: number of function inputs; the sweep covers 2^N_IN vectors.
- WORD_W, 32: output word width; must divide 2^N_IN.
- SETTLE, 0: extra wait cycles between applying a vector and sampling y.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE.
- dut_x  out  N_IN  registered input vector to the function; bit i drives xi.
- dut_y  in  1  function output y0.
- out_data  out  WORD_W  packed word; bit j = f(word_index*WORD_W + j).
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- ones_count  out  N_IN+1  running count of sampled 1s; final value equals the onset size.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, EMIT, FINISH.
- IDLE:
  - dut_x = 0, busy = 0.
  - start → APPLY; clear ones_count and the bit index.
- APPLY:
  - dut_x holds the current vector v.
  - Wait SETTLE cycles, then go to SAMPLE; with SETTLE = 0, pass straight through in one cycle.
- SAMPLE:
  - Shift dut_y into the word register at bit position (v mod WORD_W).
  - ones_count += dut_y.
  - If (v mod WORD_W) == WORD_W-1 → EMIT.
  - Otherwise increment v → APPLY.
- EMIT:
  - out_valid = 1; out_data and dut_x are frozen.
  - Leave on handshake:
    - if v == 2^N_IN-1 → FINISH;
    - otherwise clear the word register, increment v → APPLY.
- FINISH: done = 1 for one cycle; busy drops; → IDLE.
- Vector counter is N_IN+1 bits internally. It never wraps within a sweep; the sweep ends on the last vector.
- start while busy: ignored, no effect on state or counters.
- out_ready asserted outside EMIT: ignored.
- Reset at any time, including mid-sweep or mid-EMIT: immediately IDLE. All outputs take their reset values and any partial word is discarded.

## Timing
- Reset values: dut_x = 0, out_data = 0, out_valid = 0, ones_count = 0, busy = 0, done = 0.
- start sampled at edge E0:
  - busy = 1 and dut_x = 0 from E0.
  - First sample of dut_y at edge E0 + SETTLE + 1.
- Per vector: SETTLE + 1 cycles; dut_x is stable for that whole window.
- Per word: WORD_W·(SETTLE+1) cycles, plus EMIT cycles (minimum 1, with out_ready high).
- Full sweep, defaults, out_ready tied high:
  - last handshake at E0 + 1056;
  - done pulse the following cycle;
  - busy low one cycle after done.
- out_valid rises on the edge that samples the last bit of a word.
- out_valid stays high and out_data stays stable until the handshake edge; it falls on the next edge.
- ones_count updates on each SAMPLE edge and holds its final value in IDLE until the next start.

## Test plan
- Function y = 0, defaults:
  - 32 words, all 0x00000000;
  - ones_count = 0;
  - done 1056 cycles after start.
- Function y = x0:
  - every word 0xAAAAAAAA;
  - ones_count = 512.
- Function y = x9:
  - words 0–15 = 0x00000000, words 16–31 = 0xFFFFFFFF;
  - ones_count = 512.
- Backpressure with y = x5 (words alternate 0x00000000 / 0xFFFFFFFF):
  - hold out_ready low 7 cycles during word 3;
  - out_data and dut_x (= 0x07F) stay frozen;
  - all 32 words are received in order with no loss or duplication.
- Reset and SETTLE:
  - assert rst for one cycle at vector 100 → all outputs 0, state IDLE;
  - a new start produces a complete 32-word sweep;
  - a start pulse mid-sweep has no effect.
- SETTLE = 2, y = x0 with a one-cycle-delayed DUT model:
  - words remain 0xAAAAAAAA;
  - each vector lasts exactly 3 cycles;
  - done occurs 3104 cycles after start with out_ready high.
